// File: rtl/encoder_pkg.sv
// Shared widths, result type and bit-count helper for the 16-to-4 encoder.
// Consumed by encoder_16x4 and prio_find_16.
package encoder_pkg;

    localparam int IN_W   = 16;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 8;
    localparam int POP_W  = $clog2(IN_W + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    typedef struct packed {
        logic [CODE_W-1:0] y;
        logic              none;
        logic              multi;
    } enc_result_t;

    function automatic logic [POP_W-1:0] popcount16(input logic [IN_W-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < IN_W; b++) begin
            cnt = cnt + POP_W'(v[b]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_find_16.sv
// Combinational circular priority search over a 16-bit request vector,
// scanning upward or downward from i_start with wrap-around.
module prio_find_16
    import encoder_pkg::*;
#(
    parameter bit SEARCH_UP = 1'b0
) (
    input  logic [IN_W-1:0]   i_vec,
    input  logic [CODE_W-1:0] i_start,
    output logic [CODE_W-1:0] o_index,
    output logic              o_found
);

    logic [CODE_W-1:0] w_pos;

    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        w_pos   = i_start;
        // Walk furthest candidate first so the hit nearest i_start overwrites the rest.
        for (int k = IN_W - 1; k >= 0; k--) begin
            w_pos = SEARCH_UP ? (i_start + CODE_W'(k)) : (i_start - CODE_W'(k));
            if (i_vec[w_pos]) begin
                o_index = w_pos;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_16x4.sv
// 16-to-4 priority encoder with one-deep ready/valid output register and multi-hot counter.
// Define ENCODER_ROUND_ROBIN_EN for rotating priority; default is fixed highest-bit-wins.
module encoder_16x4
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [IN_W-1:0]   i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] y,
    output logic              none,
    output logic              multi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  mh_cnt
);

`ifdef ENCODER_ROUND_ROBIN_EN
    localparam bit SEARCH_UP = 1'b1;
`else
    localparam bit SEARCH_UP = 1'b0;
`endif

    logic              w_accept;
    logic [CODE_W-1:0] w_start;
    logic [CODE_W-1:0] w_index;
    logic              w_found;
    enc_result_t       w_res;

    enc_result_t       r_res_p1;
    logic              r_vld_p1;
    logic [CNT_W-1:0]  r_mh_cnt;

    // A slot frees up when it is empty or being drained on this same edge.
    assign in_ready = en && (!r_vld_p1 || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0] r_ptr;

    assign w_start = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept && w_found) begin
            r_ptr <= w_index + CODE_W'(1);
        end
    end
`else
    assign w_start = CODE_W'(IN_W - 1);
`endif

    prio_find_16 #(
        .SEARCH_UP (SEARCH_UP)
    ) u_find (
        .i_vec   (i),
        .i_start (w_start),
        .o_index (w_index),
        .o_found (w_found)
    );

    always_comb begin
        w_res       = '0;
        w_res.y     = w_found ? w_index : '0;
        w_res.none  = !w_found;
        w_res.multi = (popcount16(i) >= POP_W'(2));
    end

    // Stage p1: registered result and its valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_res_p1 <= w_res;
            r_vld_p1 <= 1'b1;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mh_cnt <= '0;
        end else if (w_accept && w_res.multi && (r_mh_cnt != CNT_MAX)) begin
            r_mh_cnt <= r_mh_cnt + CNT_W'(1);
        end
    end

    assign y         = r_res_p1.y;
    assign none      = r_res_p1.none;
    assign multi     = r_res_p1.multi;
    assign out_valid = r_vld_p1;
    assign mh_cnt    = r_mh_cnt;

endmodule

// File: tb/tb_encoder_16x4.sv
// Scoreboard bench for encoder_16x4: driver pushes expected results from a
// behavioural model, a negedge monitor pops and compares them.
module tb_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] i = 16'h0;
    logic        in_ready;
    logic [3:0]  y;
    logic        none;
    logic        multi;
    logic        out_valid;
    logic [7:0]  mh_cnt;

    encoder_16x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .i         (i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .none      (none),
        .multi     (multi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mh_cnt    (mh_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] y;
        logic       none;
        logic       multi;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic m_occ = 1'b0;
    logic m_occ_nxt = 1'b0;
    logic exp_ready = 1'b0;
    int   m_cnt = 0;
    int   m_cnt_nxt = 0;
`ifdef ENCODER_ROUND_ROBIN_EN
    int   m_ptr = 0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected encoding from the rules: highest set bit, or first set bit
    // upward from the rotating pointer.
    function automatic exp_t model(input logic [15:0] d);
        exp_t e;
        int   v;
        e.none  = (d == 16'h0);
        e.multi = ($countones(d) >= 2);
        e.y     = 4'd0;
`ifdef ENCODER_ROUND_ROBIN_EN
        if (d != 16'h0) begin
            logic hit;
            hit = 1'b0;
            for (int s = 0; s < 16; s++) begin
                if (!hit && d[(m_ptr + s) % 16]) begin
                    e.y = 4'((m_ptr + s) % 16);
                    hit = 1'b1;
                end
            end
            m_ptr = (int'(e.y) + 1) % 16;
        end
`else
        v = int'(d);
        while (v > 1) begin
            v = v / 2;
            e.y = e.y + 4'd1;
        end
`endif
        return e;
    endfunction

    task automatic decide();
        exp_t e;
        exp_ready = en && (!m_occ || out_ready);
        m_occ_nxt = m_occ;
        m_cnt_nxt = m_cnt;
        if (in_valid && exp_ready) begin
            e = model(i);
            q.push_back(e);
            m_occ_nxt = 1'b1;
            if (e.multi && m_cnt < 255) m_cnt_nxt = m_cnt + 1;
        end else if (out_ready) begin
            m_occ_nxt = 1'b0;
        end
    endtask

    task automatic cycle(input logic e_en, input logic e_v, input logic [15:0] d, input logic e_r);
        @(posedge clk);
        #1;
        m_occ     = m_occ_nxt;
        m_cnt     = m_cnt_nxt;
        en        = e_en;
        in_valid  = e_v;
        i         = d;
        out_ready = e_r;
        decide();
    endtask

    // Reset asserted between edges; first word is presented before release.
    task automatic do_reset(input logic [15:0] first_word);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_y", y, 0);
        chk("rst_none", none, 0);
        chk("rst_multi", multi, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mh_cnt", mh_cnt, 0);
        q.delete();
        m_occ = 1'b0; m_occ_nxt = 1'b0;
        m_cnt = 0;    m_cnt_nxt = 0;
`ifdef ENCODER_ROUND_ROBIN_EN
        m_ptr = 0;
`endif
        en = 1'b1; in_valid = 1'b1; i = first_word; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_out_valid", out_valid, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        decide();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, m_occ);
            chk("mh_cnt", mh_cnt, m_cnt);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL result_without_expectation: got y=%0d none=%0b multi=%0b required no result",
                             y, none, multi);
                end else begin
                    chk("y", y, q[0].y);
                    chk("none", none, q[0].none);
                    chk("multi", multi, q[0].multi);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic [15:0] mh_words [5];
        mh_words = '{16'h0003, 16'h00C0, 16'h8421, 16'hFFFF, 16'h0101};

        #1;
        chk("init_y", y, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_mh_cnt", mh_cnt, 0);
        chk("init_in_ready", in_ready, 0);
        #11;
        rst_n = 1'b1;

        // Build up a pending result and mh_cnt=5, then reset mid-transfer.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, mh_words[k], 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        chk("pre_rst_out_valid", out_valid, m_occ);
        chk("pre_rst_mh_cnt", mh_cnt, m_cnt);
        do_reset(16'h0001);

        for (int k = 1; k < 16; k++) cycle(1'b1, 1'b1, 16'(1 << k), 1'b1);
        cycle(1'b1, 1'b1, 16'h0000, 1'b1);
        cycle(1'b1, 1'b1, 16'h8421, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Rotating-priority sequence starts from pointer 0.
        do_reset(16'h8001);
        cycle(1'b1, 1'b1, 16'h8001, 1'b1);
        cycle(1'b1, 1'b1, 16'h8001, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Back-pressure then drain-and-accept on the same edge.
        cycle(1'b1, 1'b1, 16'h0010, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0100, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Enable low blocks acceptance but not draining.
        cycle(1'b1, 1'b1, 16'h0040, 1'b0);
        cycle(1'b0, 1'b1, 16'h0400, 1'b0);
        cycle(1'b0, 1'b1, 16'h0400, 1'b1);
        cycle(1'b0, 1'b1, 16'h0400, 1'b1);
        cycle(1'b0, 1'b1, 16'h0400, 1'b1);

        repeat (300) begin
            case ($urandom_range(0, 3))
                0:       d = 16'h0;
                1:       d = 16'(1 << $urandom_range(0, 15));
                default: d = 16'($urandom);
            endcase
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
        end

        repeat (260) begin
            d = 16'($urandom);
            if ($countones(d) < 2) d = d | 16'h0101;
            cycle(1'b1, 1'b1, d, 1'b1);
        end

        repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        #1;
        chk("mh_cnt_saturated", mh_cnt, 255);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
